input_debounce7: RTL and testbench
==================================

INPUT_DEBOUNCE7 -- requirements
Module: input_debounce7

Interface
REQ-001: The block SHALL have parameter WIDTH, default 7, giving the number of independent input bits (range 1..32).
REQ-002: The block SHALL have parameter STABLE_CYCLES, default 16, giving the consecutive stable cycles needed to accept a change (range 1..65535).
REQ-003: The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004: The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005: The block SHALL have port I, input, WIDTH bits: raw asynchronous pins (switches/buttons).
REQ-006: The block SHALL have port O, output, WIDTH bits: debounced level, suitable to drive the downstream register's I input directly.
REQ-007: The block SHALL have port CHANGED, output, 1 bit: one-cycle strobe asserted when any bit of O changed on this edge.

Function
REQ-008: Each bit of I SHALL pass through a 2-flop synchronizer; the second-stage value is the synced bit S.
REQ-009: Each bit SHALL own a counter of width ceil(log2(STABLE_CYCLES+1)); the counter SHALL clear on any edge where S equals O.
REQ-010: On an edge where S differs from O and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-011: On an edge where S differs from O and the counter equals STABLE_CYCLES-1, O for that bit SHALL take S and the counter SHALL clear on the same edge.
REQ-012: Latency: if I changes before edge 0 and stays constant, O SHALL update on edge STABLE_CYCLES+1 (edge 2 when STABLE_CYCLES=1).
REQ-013: A glitch in S lasting fewer than STABLE_CYCLES cycles SHALL leave O unchanged and return the counter to 0.
REQ-014: Bits SHALL be fully independent; simultaneous changes on several bits SHALL each be accepted on their own schedule.
REQ-015: CHANGED SHALL be registered and high for exactly the cycle following any O update; if several bits update on the same edge, one pulse results.
REQ-016: Counters SHALL never wrap; saturation is precluded by REQ-011.

Reset
REQ-017: While RESET is high, the synchronizers, counters, O and CHANGED SHALL all be 0, regardless of CLK.
REQ-018: Deassertion of RESET mid-bounce SHALL restart qualification from counter 0; a held-high input SHALL then produce O=1 on edge STABLE_CYCLES+1 after the first post-reset edge.

Configuration
REQ-019: With macro INPUT_DEBOUNCE_EDGE_EN defined, the block SHALL add outputs RISE and FALL, each WIDTH bits and registered, pulsing for one cycle per bit when O goes 0->1 or 1->0 respectively; both SHALL reset to 0.
REQ-020: Without INPUT_DEBOUNCE_EDGE_EN, RISE, FALL and their logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-021: Package input_debounce_pkg SHALL hold the WIDTH and STABLE_CYCLES defaults, and a function returning the counter width.
REQ-022: Per-bit logic (synchronizer, counter, output flop, edge flops) SHALL live in sub-module debounce_bit, instantiated WIDTH times by a generate loop; CHANGED is the registered OR of the per-bit update signals.
REQ-023: The design SHALL contain no combinational path from I to O; all flops SHALL use CLK and async RESET only.

Verification (WIDTH=7, STABLE_CYCLES=4)
REQ-024: Reset, then I=7'h00 for 10 cycles -> O=7'h00, CHANGED never asserted.
REQ-025: I steps 7'h00->7'h55 before edge 0 -> O=7'h55 after edge 5, CHANGED=1 only in the cycle after edge 5.
REQ-026: Bit 0 toggles high for 3 cycles then low again -> O[0] stays 0, no CHANGED pulse; the same toggle held for 4 synced cycles -> O[0]=1.
REQ-027: Bit 1 rises at edge 0 and bit 6 rises at edge 2 -> O[1] updates at edge 5 and O[6] at edge 7, giving two separate CHANGED pulses.
REQ-028: I=7'h7F is held and RESET is pulsed high mid-count (at edge 3) -> O=7'h00 during reset; O=7'h7F at edge 5 after the first post-reset edge.
REQ-029: With INPUT_DEBOUNCE_EDGE_EN, O[2] goes 0->1->0 -> RISE=7'h04 for one cycle, then later FALL=7'h04 for one cycle.

Source files
------------

// File: rtl/input_debounce_pkg.sv
// Shared defaults and sizing helper for the input debouncer.
// Optional RISE/FALL edge outputs are enabled with INPUT_DEBOUNCE_EDGE_EN.
package input_debounce_pkg;

  localparam int DEFAULT_WIDTH         = 7;
  localparam int DEFAULT_STABLE_CYCLES = 16;

  // Bits needed to hold 0..stable_cycles.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced channel: 2-flop synchronizer, stability counter, output flop.
// Edge pulse flops are present only with INPUT_DEBOUNCE_EDGE_EN.
module debounce_bit
  import input_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic update
`ifdef INPUT_DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int            CW   = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          sync_a_reg;
  logic          sync_b_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;

  // Accept on the edge where the counter has already seen STABLE_CYCLES-1
  // disagreeing samples and the current one still disagrees.
  assign update = (sync_b_reg != level_reg) && (cnt_reg == LAST);
  assign level  = level_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_reg <= 1'b0;
      sync_b_reg <= 1'b0;
      cnt_reg    <= '0;
      level_reg  <= 1'b0;
    end else begin
      sync_a_reg <= pin;
      sync_b_reg <= sync_a_reg;
      if (sync_b_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (update) begin
        level_reg <= sync_b_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic rise_reg;
  logic fall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= update & sync_b_reg;
      fall_reg <= update & ~sync_b_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;
`endif

endmodule

// File: rtl/input_debounce7.sv
// Multi-bit switch/button debouncer with a single "any output changed" strobe.
// Define INPUT_DEBOUNCE_EDGE_EN to add per-bit RISE/FALL pulse outputs.
module input_debounce7
  import input_debounce_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             CHANGED
`ifdef INPUT_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
`endif
);

  logic [WIDTH-1:0] update;
  logic             changed_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk   (CLK),
      .rst   (RESET),
      .pin   (I[gi]),
      .level (O[gi]),
      .update(update[gi])
`ifdef INPUT_DEBOUNCE_EDGE_EN
      ,
      .rise  (RISE[gi]),
      .fall  (FALL[gi])
`endif
    );
  end

  // Same edge as the O update, so the strobe covers the cycle after it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= |update;
    end
  end

  assign CHANGED = changed_reg;

endmodule

// File: tb/tb_input_debounce7.sv
// Self-checking bench for input_debounce7 (WIDTH=7, STABLE_CYCLES=4): table
// vectors, hand-written corner sequences and a randomized run vs a window model.
module tb_input_debounce7;

  localparam int W  = 7;
  localparam int SC = 4;

  logic         CLK   = 1'b0;
  logic         RESET = 1'b0;
  logic [W-1:0] I     = '0;
  logic [W-1:0] O;
  logic         CHANGED;
`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic [W-1:0] RISE;
  logic [W-1:0] FALL;
`endif

  input_debounce7 #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .I      (I),
    .O      (O),
    .CHANGED(CHANGED)
`ifdef INPUT_DEBOUNCE_EDGE_EN
    ,
    .RISE   (RISE),
    .FALL   (FALL)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Reference model: S is the pin value two edges back; a bit flips when the
  // last SC synced samples all disagree with its current output.
  logic [W-1:0] m_d1, m_d2, m_o, m_rise, m_fall;
  logic         m_chg;
  logic [W-1:0] m_win [SC];

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_o = '0; m_chg = 1'b0; m_rise = '0; m_fall = '0;
    for (int k = 0; k < SC; k++) m_win[k] = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] pin);
    logic [W-1:0] s_now;
    bit all_diff;
    s_now = m_d2;
    m_d2  = m_d1;
    m_d1  = pin;
    for (int k = SC - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = s_now;
    m_chg = 1'b0; m_rise = '0; m_fall = '0;
    for (int b = 0; b < W; b++) begin
      all_diff = 1;
      for (int k = 0; k < SC; k++) if (m_win[k][b] == m_o[b]) all_diff = 0;
      if (all_diff) begin
        m_o[b] = ~m_o[b];
        m_chg  = 1'b1;
        if (m_o[b]) m_rise[b] = 1'b1;
        else        m_fall[b] = 1'b1;
      end
    end
  endtask

  // Called just after an edge (or after reset release); returns 1 after the next edge.
  task automatic tick(input logic [W-1:0] v);
    I = v;
    @(posedge CLK);
    model_edge(v);
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    RESET = 1'b1;
    I     = v;
    model_reset();
    #1;
    check("rst_async.O", 32'(O), 32'h0);
    check("rst_async.CHANGED", 32'(CHANGED), 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("rst_held.O", 32'(O), 32'h0);
    check("rst_held.CHANGED", 32'(CHANGED), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] o;
    logic         chg;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] cur;
    logic [W-1:0] mask;
    logic [W-1:0] exp_o;

    // Idle 10 cycles, then step to 7'h55: accepted on edge 5.
    for (int k = 0; k < 10; k++) tbl[k] = '{i: 7'h00, o: 7'h00, chg: 1'b0};
    for (int k = 0; k < 5; k++)  tbl[10 + k] = '{i: 7'h55, o: 7'h00, chg: 1'b0};
    tbl[15] = '{i: 7'h55, o: 7'h55, chg: 1'b1};
    tbl[16] = '{i: 7'h55, o: 7'h55, chg: 1'b0};

    #2;
    do_reset(7'h00);
    for (int k = 0; k < 17; k++) begin
      tick(tbl[k].i);
      check($sformatf("tbl[%0d].O", k), 32'(O), 32'(tbl[k].o));
      check($sformatf("tbl[%0d].CHANGED", k), 32'(CHANGED), 32'(tbl[k].chg));
    end

    // Three-cycle glitch on bit 0 is rejected.
    do_reset(7'h00);
    tick(7'h00); tick(7'h00);
    for (int k = 0; k < 11; k++) begin
      tick((k < 3) ? 7'h01 : 7'h00);
      check($sformatf("glitch[%0d].O", k), 32'(O), 32'h0);
      check($sformatf("glitch[%0d].CHANGED", k), 32'(CHANGED), 32'h0);
    end
    // Held high: accepted on edge 5.
    for (int k = 0; k < 7; k++) begin
      tick(7'h01);
      check($sformatf("hold[%0d].O", k), 32'(O), (k >= 5) ? 32'h01 : 32'h00);
      check($sformatf("hold[%0d].CHANGED", k), 32'(CHANGED), (k == 5) ? 32'h1 : 32'h0);
    end

    // Bit 1 rises at edge 0, bit 6 at edge 2: independent schedules.
    do_reset(7'h00);
    for (int k = 0; k < 9; k++) begin
      tick((k < 2) ? 7'h02 : 7'h42);
      exp_o = (k >= 7) ? 7'h42 : (k >= 5) ? 7'h02 : 7'h00;
      check($sformatf("indep[%0d].O", k), 32'(O), 32'(exp_o));
      check($sformatf("indep[%0d].CHANGED", k), 32'(CHANGED), (k == 5 || k == 7) ? 32'h1 : 32'h0);
    end

    // Reset pulsed mid-count restarts qualification.
    do_reset(7'h00);
    for (int k = 0; k < 3; k++) begin
      tick(7'h7F);
      check($sformatf("midrst_pre[%0d].O", k), 32'(O), 32'h0);
    end
    do_reset(7'h7F);
    for (int k = 0; k < 7; k++) begin
      tick(7'h7F);
      check($sformatf("midrst[%0d].O", k), 32'(O), (k >= 5) ? 32'h7F : 32'h00);
      check($sformatf("midrst[%0d].CHANGED", k), 32'(CHANGED), (k == 5) ? 32'h1 : 32'h0);
    end

`ifdef INPUT_DEBOUNCE_EDGE_EN
    do_reset(7'h00);
    for (int k = 0; k < 7; k++) begin
      tick(7'h04);
      check($sformatf("rise[%0d].RISE", k), 32'(RISE), (k == 5) ? 32'h04 : 32'h00);
      check($sformatf("rise[%0d].FALL", k), 32'(FALL), 32'h00);
    end
    for (int k = 0; k < 7; k++) begin
      tick(7'h00);
      check($sformatf("fall[%0d].FALL", k), 32'(FALL), (k == 5) ? 32'h04 : 32'h00);
      check($sformatf("fall[%0d].RISE", k), 32'(RISE), 32'h00);
    end
`endif

    // Randomized run: bits flip with probability 1/5 per cycle.
    do_reset(7'h00);
    cur = '0;
    for (int t = 0; t < 600; t++) begin
      if (t == 300) begin
        cur = 7'($urandom);
        do_reset(cur);
      end
      for (int b = 0; b < W; b++) mask[b] = ($urandom_range(0, 4) == 0);
      cur = cur ^ mask;
      tick(cur);
      check($sformatf("rand[%0d].O", t), 32'(O), 32'(m_o));
      check($sformatf("rand[%0d].CHANGED", t), 32'(CHANGED), 32'(m_chg));
`ifdef INPUT_DEBOUNCE_EDGE_EN
      check($sformatf("rand[%0d].RISE", t), 32'(RISE), 32'(m_rise));
      check($sformatf("rand[%0d].FALL", t), 32'(FALL), 32'(m_fall));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
